// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared RV32 core constants and the IF/ID pipeline payload type.
package fetch_stage_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR_RV32 = 32'h0000_0013;

  // Sequential fetch advances one 32-bit instruction word.
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

endpackage : fetch_stage_ctrl_pkg

// File: rtl/fetch_stage_ctrl_if.sv
// Hazard-control inputs, instruction memory data and fetch-stage outputs.
interface fetch_stage_ctrl_if
  import fetch_stage_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic              start_i;
  logic              PCWrite_i;
  logic              Stall_i;
  logic              Flush_i;
  logic [XLEN-1:0]   BranchTarget_i;
  logic [XLEN-1:0]   Instr_i;
  logic [XLEN-1:0]   PC_o;
  logic [XLEN-1:0]   IFID_PC_o;
  logic [XLEN-1:0]   IFID_Instr_o;
  logic              IFID_Valid_o;
  logic [CNT_W-1:0]  StallCnt_o;
  logic [CNT_W-1:0]  FlushCnt_o;

  // Core-side driver: hazard unit, branch unit and instruction memory.
  modport master (
    output start_i, PCWrite_i, Stall_i, Flush_i, BranchTarget_i, Instr_i,
    input  PC_o, IFID_PC_o, IFID_Instr_o, IFID_Valid_o, StallCnt_o, FlushCnt_o
  );

  // Fetch stage itself.
  modport slave (
    input  start_i, PCWrite_i, Stall_i, Flush_i, BranchTarget_i, Instr_i,
    output PC_o, IFID_PC_o, IFID_Instr_o, IFID_Valid_o, StallCnt_o, FlushCnt_o
  );

endinterface : fetch_stage_ctrl_if

// File: rtl/fetch_stage_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles, holding once saturated.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule : sat_counter

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, IF/ID register and stall/flush event counters.
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_RV32,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fetch_stage_ctrl_if.slave  bus
);

  logic            w_stall_eff;
  logic            w_flush_eff;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  ifid_t           r_ifid;
  ifid_t           w_ifid_nxt;
  ifid_t           w_ifid_bubble;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_flush_cnt;

  // A stalled branch has stale operands, so stall masks flush.
  assign w_stall_eff = bus.start_i & bus.Stall_i;
  assign w_flush_eff = bus.start_i & bus.Flush_i & ~bus.Stall_i;

  assign w_ifid_bubble = '{pc: r_pc, instr: NOP_INSTR, valid: 1'b0};

  // Next PC and IF/ID contents; priority idle > stall > flush > normal.
  always_comb begin
    w_pc_nxt   = r_pc;
    w_ifid_nxt = r_ifid;
    if (!bus.start_i) begin
      w_ifid_nxt = w_ifid_bubble;
    end else if (w_stall_eff) begin
      if (bus.PCWrite_i) begin
        w_pc_nxt = r_pc + PC_INC;
      end
    end else if (w_flush_eff) begin
      w_ifid_nxt = w_ifid_bubble;
      if (bus.PCWrite_i) begin
        w_pc_nxt = bus.BranchTarget_i;
      end
    end else begin
      w_ifid_nxt = '{pc: r_pc, instr: bus.Instr_i, valid: 1'b1};
      if (bus.PCWrite_i) begin
        w_pc_nxt = r_pc + PC_INC;
      end
    end
  end

  // PC and IF/ID state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc   <= RESET_PC;
      r_ifid <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      r_pc   <= w_pc_nxt;
      r_ifid <= w_ifid_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (w_stall_eff),
    .o_cnt (w_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_en  (w_flush_eff),
    .o_cnt (w_flush_cnt)
  );

  assign bus.PC_o         = r_pc;
  assign bus.IFID_PC_o    = r_ifid.pc;
  assign bus.IFID_Instr_o = r_ifid.instr;
  assign bus.IFID_Valid_o = r_ifid.valid;
  assign bus.StallCnt_o   = w_stall_cnt;
  assign bus.FlushCnt_o   = w_flush_cnt;

endmodule : fetch_stage_ctrl

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: directed plan plus randomized hazards vs. a behavioural model.
module tb_fetch_stage_ctrl;
  import fetch_stage_ctrl_pkg::*;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SCNT_W  = 3;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          BIG_MAX = 65535;
  localparam int          SML_MAX = 7;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  fetch_stage_ctrl_if #(.CNT_W(CNT_W))  bus   ();
  fetch_stage_ctrl_if #(.CNT_W(SCNT_W)) bus_s ();

  // Narrow-counter copy sees identical stimulus so saturation is reachable quickly.
  assign bus_s.start_i        = bus.start_i;
  assign bus_s.PCWrite_i      = bus.PCWrite_i;
  assign bus_s.Stall_i        = bus.Stall_i;
  assign bus_s.Flush_i        = bus.Flush_i;
  assign bus_s.BranchTarget_i = bus.BranchTarget_i;
  assign bus_s.Instr_i        = bus.Instr_i;

  fetch_stage_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CNT_W)) u_dut (
    .clk_i (clk_i), .rst_i (rst_i), .bus (bus)
  );

  fetch_stage_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(SCNT_W)) u_dut_s (
    .clk_i (clk_i), .rst_i (rst_i), .bus (bus_s)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: architectural view, counters kept as unbounded event tallies.
  logic [31:0] m_pc, m_ipc, m_instr;
  logic        m_valid;
  int          m_scnt, m_fcnt;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] sat(input int v, input int mx);
    return 32'((v > mx) ? mx : v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_valid = 1'b0;
    m_scnt = 0; m_fcnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},     bus.PC_o,                 m_pc);
    chk({tag, ".ifpc"},   bus.IFID_PC_o,            m_ipc);
    chk({tag, ".ifins"},  bus.IFID_Instr_o,         m_instr);
    chk({tag, ".ifval"},  32'(bus.IFID_Valid_o),    32'(m_valid));
    chk({tag, ".scnt"},   32'(bus.StallCnt_o),      sat(m_scnt, BIG_MAX));
    chk({tag, ".fcnt"},   32'(bus.FlushCnt_o),      sat(m_fcnt, BIG_MAX));
    chk({tag, ".scnt_s"}, 32'(bus_s.StallCnt_o),    sat(m_scnt, SML_MAX));
    chk({tag, ".fcnt_s"}, 32'(bus_s.FlushCnt_o),    sat(m_fcnt, SML_MAX));
  endtask

  task automatic check_reset_consts(input string tag);
    chk({tag, ".pc"},    bus.PC_o,              32'h0);
    chk({tag, ".ifpc"},  bus.IFID_PC_o,         32'h0);
    chk({tag, ".ifins"}, bus.IFID_Instr_o,      NOP);
    chk({tag, ".ifval"}, 32'(bus.IFID_Valid_o), 32'h0);
    chk({tag, ".scnt"},  32'(bus.StallCnt_o),   32'h0);
    chk({tag, ".fcnt"},  32'(bus.FlushCnt_o),   32'h0);
  endtask

  task automatic drive(input bit st, input bit sl, input bit fl, input bit pw,
                       input logic [31:0] bt);
    bus.start_i        = st;
    bus.Stall_i        = sl;
    bus.Flush_i        = fl;
    bus.PCWrite_i      = pw;
    bus.BranchTarget_i = bt;
    bus.Instr_i        = mem_rd(m_pc);
  endtask

  // One clock of stimulus: apply inputs at negedge, advance the model, check at next negedge.
  task automatic cycle(input bit st, input bit sl, input bit fl, input bit pw,
                       input logic [31:0] bt, input string tag);
    drive(st, sl, fl, pw, bt);
    if (!st) begin
      m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0;
    end else if (sl) begin
      m_scnt++;
      if (pw) m_pc = m_pc + 32'd4;
    end else if (fl) begin
      m_fcnt++;
      m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0;
      if (pw) m_pc = bt;
    end else begin
      m_ipc = m_pc; m_instr = mem_rd(m_pc); m_valid = 1'b1;
      if (pw) m_pc = m_pc + 32'd4;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    check_all(tag);
  endtask

  initial begin
    bit          st, sl, fl, pw;
    logic [31:0] bt;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_consts("reset");
    rst_i = 1'b1;

    // Straight-line fetch of A, B
    cycle(1, 0, 0, 1, 32'h0, "fetch_a");
    cycle(1, 0, 0, 1, 32'h0, "fetch_b");
    // Load-use stall at PC=8, then resume with C
    cycle(1, 1, 0, 0, 32'h0, "loaduse");
    chk("loaduse.pc_const", bus.PC_o, 32'h8);
    cycle(1, 0, 0, 1, 32'h0, "fetch_c");
    chk("fetch_c.ifpc_const", bus.IFID_PC_o, 32'h8);
    // Taken branch at PC=12
    cycle(1, 0, 1, 1, 32'h40, "flush40");
    chk("flush40.pc_const", bus.PC_o, 32'h40);
    cycle(1, 0, 0, 1, 32'h0, "at40");
    // Stall masks flush, then the branch redirects next cycle
    cycle(1, 1, 1, 0, 32'h100, "stall_flush");
    cycle(1, 0, 1, 1, 32'h100, "flush_after");
    chk("flush_after.pc_const", bus.PC_o, 32'h100);
    // PC wrap
    cycle(1, 0, 1, 1, 32'hFFFF_FFFC, "to_top");
    cycle(1, 0, 0, 1, 32'h0, "wrap");
    chk("wrap.pc_const", bus.PC_o, 32'h0);
    // Idle, lost redirect, stall with PCWrite, unaligned target
    cycle(0, 1, 1, 1, 32'h200, "idle");
    cycle(0, 0, 0, 1, 32'h200, "idle2");
    cycle(1, 0, 1, 0, 32'h300, "lost_redirect");
    cycle(1, 1, 0, 1, 32'h0, "stall_pcw");
    cycle(1, 0, 1, 1, 32'h0000_1233, "unaligned");

    // Randomized hazard stream
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 9) != 0);
      sl = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 4) == 0);
      pw = sl ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) != 0);
      bt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cycle(st, sl, fl, pw, bt, "rand");
    end

    // Asynchronous reset asserted between edges while stalled with a pending flush
    cycle(1, 1, 1, 0, 32'h500, "pre_rst");
    drive(1, 1, 1, 1, 32'h500);
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    check_reset_consts("async_rst");
    check_all("async_rst_s");
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle(1, 0, 0, 1, 32'h0, "restart0");
    chk("restart0.ifpc_const", bus.IFID_PC_o, 32'h0);
    cycle(1, 0, 0, 1, 32'h0, "restart1");
    cycle(1, 0, 0, 1, 32'h0, "restart2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_fetch_stage_ctrl

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
Front-end pipeline block for the 5-stage RV32 core. It owns the PC register and the IF/ID pipeline register, and it consumes the hazard/branch control signals: PCWrite_i, Stall_i and Flush_i. It holds, advances, redirects or bubbles the fetch stream each cycle. It also keeps saturating stall and flush event counters for debug and performance reporting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction word injected into IF/ID on flush or idle (addi x0,x0,0)
CNT_W, 16, width of each event counter

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  core run enable; low = fetch idle
PCWrite_i  in  1  from hazard unit; 1 = PC may update
Stall_i  in  1  from hazard unit; 1 = hold IF/ID contents
Flush_i  in  1  branch taken in ID; squash IF instruction, redirect PC
BranchTarget_i  in  32  redirect address, valid with Flush_i
Instr_i  in  32  instruction memory read data for address PC_o (combinational memory)
PC_o  out  32  current fetch address
IFID_PC_o  out  32  PC of instruction held in IF/ID
IFID_Instr_o  out  32  instruction held in IF/ID
IFID_Valid_o  out  1  1 = IF/ID holds a real instruction
StallCnt_o  out  CNT_W  cycles with effective stall
FlushCnt_o  out  CNT_W  cycles with effective flush

Behaviour:
- Reset (rst_i low, asynchronous): PC_o=RESET_PC, IFID_PC_o=0, IFID_Instr_o=NOP_INSTR, IFID_Valid_o=0, both counters 0. Release is synchronous to the next clk_i edge; the first fetch is at RESET_PC.
- Effective signals: stall_eff = start_i & Stall_i. flush_eff = start_i & Flush_i & ~Stall_i. A stalled branch has invalid operands, so stall wins. The flush is ignored that cycle and the branch re-evaluates next cycle.
- Single-cycle state update on posedge clk_i. Priority: start_i low > stall > flush > normal.
- start_i low: PC held. IF/ID loads NOP_INSTR with Valid=0 and PC=PC_o. Counters held.
- Stall (stall_eff=1): IF/ID fully held (PC, Instr, Valid). PC updates only if PCWrite_i=1 (hazard unit normally drives it 0 with Stall). StallCnt_o increments.
- Flush (flush_eff=1): IF/ID loads NOP_INSTR, Valid=0, IFID_PC_o=PC_o. If PCWrite_i=1, PC<=BranchTarget_i; if PCWrite_i=0, PC is held and the redirect is lost (a legal hazard unit never produces this). FlushCnt_o increments.
- Normal: IF/ID loads {PC_o, Instr_i, Valid=1}. If PCWrite_i=1, PC<=PC_o+4; otherwise PC is held.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. BranchTarget_i is used unmodified; bits [1:0] are not checked.
- Counters saturate at all-ones and do not wrap.
- No combinational path from any input to any output. All outputs are registered; PC_o is the register itself.
- Reset asserted mid-stall or mid-flush: all state returns to reset values immediately, and no pending redirect survives.

Decomposition:
- Shared core package holds: XLEN=32, NOP_INSTR_RV32 constant, and a PC increment constant of 4. The parameter default references the package constant.
- One sub-module: sat_counter (CNT_W wide, enable input, async active-low reset), instantiated twice for the stall and flush counters.
- PC register and IF/ID register stay inline in this block.

Test Plan:
- Reset then start_i=1, Instr_i=A,B,C on successive cycles, no hazards -> PC_o 0,4,8,12; IF/ID shows (0,A,1),(4,B,1),(8,C,1); counters stay 0.
- Load-use: at PC=8, assert Stall_i=1 and PCWrite_i=0 for 1 cycle -> PC_o stays 8, IF/ID holds (4,B,1), StallCnt_o=1; the next cycle resumes with (8,C,1).
- Flush at PC=12 with BranchTarget_i=32'h40, PCWrite_i=1 -> next cycle PC_o=0x40, IF/ID=(12,NOP_INSTR,0), FlushCnt_o=1.
- Flush_i and Stall_i both 1, PCWrite_i=0 -> no redirect, IF/ID held, StallCnt_o+1, FlushCnt_o unchanged. The next cycle has Flush_i only -> redirect occurs.
- PC_o forced to 32'hFFFF_FFFC via flush, then normal fetch -> PC_o=0. Separately, preload the counter near max and hold Stall_i -> StallCnt_o sticks at 16'hFFFF.
- Assert rst_i low mid-stall, between clock edges -> outputs reach reset values without a clock edge; after release, fetch restarts at RESET_PC.
